// File: rtl/vbuf_pkg.sv
// Shared widths and defaults for the video byte-to-word packer.
package vbuf_pkg;
  localparam int VBUF_BYTE_W         = 8;
  localparam int VBUF_WORD_W         = 32;
  localparam int VBUF_BYTES_PER_WORD = 4;
  localparam int VBUF_FIFO_DEPTH     = 8;
  localparam int VBUF_PART_W         = VBUF_WORD_W - VBUF_BYTE_W;
endpackage

// File: rtl/vbuf_word_fifo.sv
// Synchronous first-word-fall-through word FIFO; push and pop may share an edge even when full.
module vbuf_word_fifo
  import vbuf_pkg::*;
#(
  parameter int DEPTH = VBUF_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [VBUF_WORD_W-1:0] wdata_i,
  output logic [VBUF_WORD_W-1:0] rdata_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [LW-1:0]          level_o,
  output logic                   drop_o
);
  logic [VBUF_WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_q, rd_q;
  logic [LW-1:0]          level_q;
  logic                   push_ok, pop_ok;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  // Gate the head so an empty FIFO reads as zero rather than stale storage.
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;

  assign pop_ok  = pop_i && valid_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (en_i) begin
      if (push_ok) wr_q <= AW'(wr_q + 1'b1);
      if (pop_ok)  rd_q <= AW'(rd_q + 1'b1);
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && en_i && push_ok) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/vbuf_packer.sv
// Packs a byte stream big-endian into 32-bit words, with zero-padded flush, into a word FIFO.
module vbuf_packer
  import vbuf_pkg::*;
#(
  parameter int FIFO_DEPTH = VBUF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic [VBUF_BYTE_W-1:0]       vbuf_in,
  input  logic                         vbuf_wr_in,
  input  logic                         flush,
  input  logic                         out_rd,
  output logic [VBUF_WORD_W-1:0]       vbuf_word,
  output logic                         vbuf_valid,
  output logic                         vbuf_full,
  output logic [$clog2(FIFO_DEPTH):0]  vbuf_level,
  output logic                         vbuf_overflow
);
  logic [1:0]             cnt_q, cnt_d;
  logic [VBUF_PART_W-1:0] part_q, part_d;
  logic                   ovf_q;
  logic                   push;
  logic [VBUF_WORD_W-1:0] push_word;
  logic                   drop;

  // Lanes above the byte count stay zero, so a flush is just the partial shifted up one lane.
  always_comb begin
    cnt_d     = cnt_q;
    part_d    = part_q;
    push      = 1'b0;
    push_word = '0;
    if (vbuf_wr_in) begin
      if (cnt_q == 2'd3) begin
        push      = 1'b1;
        push_word = {part_q, vbuf_in};
        cnt_d     = 2'd0;
        part_d    = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0:    part_d = {vbuf_in, 16'h0};
          2'd1:    part_d = {part_q[23:16], vbuf_in, 8'h0};
          default: part_d = {part_q[23:8], vbuf_in};
        endcase
      end
    end
    if (flush && !push && (cnt_d != 2'd0)) begin
      push      = 1'b1;
      push_word = {part_d, 8'h0};
      cnt_d     = 2'd0;
      part_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      part_q <= '0;
      ovf_q  <= 1'b0;
    end else if (clk_en) begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign vbuf_overflow = ovf_q;

  vbuf_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .en_i    (clk_en),
    .push_i  (push),
    .pop_i   (out_rd),
    .wdata_i (push_word),
    .rdata_o (vbuf_word),
    .valid_o (vbuf_valid),
    .full_o  (vbuf_full),
    .level_o (vbuf_level),
    .drop_o  (drop)
  );
endmodule
